video_timing_gen: RTL and testbench

// - Parametrised successor to pixel_iterator: generates the raster (x/y), hs/vs/de and the swap strobe.
// - Adds run-time pixel scaling (1x/2x/4x) for low-resolution frame buffers.
// - Adds a LOOKAHEAD lead on x/y, so frame-buffer read latency is hidden.
// - Adds a frame counter. Sits between the PLL/ce domain and frame_buffer/dvi_tx in top.

---
 rtl/video_pkg.sv | 35 +++
 rtl/sync_delay_line.sv | 33 +++
 rtl/video_timing_gen.sv | 152 +++++++++++++++
 tb/tb_video_timing_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared timing description types, the VGA 640x480@60 timing constant,
// and the pixel-scale encoding used by video_timing_gen.
package video_pkg;

    // Timing of one raster axis: active, front porch, sync, remainder is back porch.
    typedef struct packed {
        logic [15:0] active;
        logic [15:0] front_porch;
        logic [15:0] sync;
        logic [15:0] total;
        logic        polarity;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t hor;
        axis_timing_t ver;
    } timing_t;

    localparam timing_t VGA_640x480 = '{
        hor: '{active: 16'd640, front_porch: 16'd16, sync: 16'd96, total: 16'd800, polarity: 1'b0},
        ver: '{active: 16'd480, front_porch: 16'd10, sync: 16'd2,  total: 16'd525, polarity: 1'b0}
    };

    typedef enum logic [1:0] {
        SCALE_1X = 2'd0,
        SCALE_2X = 2'd1,
        SCALE_4X = 2'd2
    } scale_e;

    // Code 3 has no 8x mode behind it; it saturates to 4x.
    function automatic scale_e clamp_scale(input logic [1:0] code);
        return (code >= 2'd2) ? SCALE_4X : scale_e'(code);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth, clock-enabled delay line that realigns hs/vs/de with the
// pixel data fetched LOOKAHEAD cycles earlier from the x/y coordinates.
// There is always one stage more than DEPTH so the outputs are registered
// even when no lead is requested.
module sync_delay_line #(
    parameter int               WIDTH       = 3,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH:0][WIDTH-1:0] stage_reg;

    // Shift the chain on every enabled cycle; reset flushes it to the idle levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= {(DEPTH + 1){RESET_VALUE}};
        end else if (ce) begin
            stage_reg[0] <= din;
            for (int i = 1; i <= DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign dout = stage_reg[DEPTH];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, scaled source coordinates that lead
// the sync/enable outputs by LOOKAHEAD cycles, a per-frame scale latch, the
// frame-buffer swap strobe and a frame counter.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int   HOR_TOTAL_PIXELS       = int'(VGA_640x480.hor.total),
    parameter int   HOR_ACTIVE_PIXELS      = int'(VGA_640x480.hor.active),
    parameter int   HOR_FRONT_PORCH_PIXELS = int'(VGA_640x480.hor.front_porch),
    parameter int   HOR_SYNC_PIXELS        = int'(VGA_640x480.hor.sync),
    parameter logic HOR_SYNC_POLARITY      = VGA_640x480.hor.polarity,
    parameter int   VER_TOTAL_PIXELS       = int'(VGA_640x480.ver.total),
    parameter int   VER_ACTIVE_PIXELS      = int'(VGA_640x480.ver.active),
    parameter int   VER_FRONT_PORCH_PIXELS = int'(VGA_640x480.ver.front_porch),
    parameter int   VER_SYNC_PIXELS        = int'(VGA_640x480.ver.sync),
    parameter logic VER_SYNC_POLARITY      = VGA_640x480.ver.polarity,
    parameter int   LOOKAHEAD              = 2,
    parameter int   FRAME_CNT_WIDTH        = 16,
    parameter int   X_WIDTH                = $clog2(HOR_ACTIVE_PIXELS),
    parameter int   Y_WIDTH                = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic                       clk_rgb,
    input  logic                       rst_n,
    input  logic                       ce,
    input  logic [1:0]                 scale,
    output logic [X_WIDTH-1:0]         x,
    output logic [Y_WIDTH-1:0]         y,
    output logic                       hs,
    output logic                       vs,
    output logic                       de,
    output logic                       swap,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
    output logic [1:0]                 scale_active
);

    localparam int H_W = $clog2(HOR_TOTAL_PIXELS);
    localparam int V_W = $clog2(VER_TOTAL_PIXELS);

    localparam logic [H_W-1:0] H_ACT        = H_W'(HOR_ACTIVE_PIXELS);
    localparam logic [H_W-1:0] H_SYNC_FIRST = H_W'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH_PIXELS);
    localparam logic [H_W-1:0] H_SYNC_LAST  = H_W'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH_PIXELS + HOR_SYNC_PIXELS - 1);
    localparam logic [H_W-1:0] H_LAST       = H_W'(HOR_TOTAL_PIXELS - 1);

    localparam logic [V_W-1:0] V_ACT        = V_W'(VER_ACTIVE_PIXELS);
    localparam logic [V_W-1:0] V_SYNC_FIRST = V_W'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH_PIXELS);
    localparam logic [V_W-1:0] V_SYNC_LAST  = V_W'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH_PIXELS + VER_SYNC_PIXELS - 1);
    localparam logic [V_W-1:0] V_LAST       = V_W'(VER_TOTAL_PIXELS - 1);
    localparam logic [V_W-1:0] V_LAST_ACT   = V_W'(VER_ACTIVE_PIXELS - 1);

    // Idle levels of {de, vs, hs}, used for reset and to flush the delay line.
    localparam logic [2:0] SYNC_IDLE = {1'b0, ~VER_SYNC_POLARITY, ~HOR_SYNC_POLARITY};

    logic [H_W-1:0]             h_reg;
    logic [V_W-1:0]             v_reg;
    logic [X_WIDTH-1:0]         x_reg;
    logic [Y_WIDTH-1:0]         y_reg;
    scale_e                     scale_reg;
    logic                       swap_reg;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_reg;

    logic [H_W-1:0]     h_next;
    logic [V_W-1:0]     v_next;
    logic               last_h;
    logic               last_v;
    logic               frame_wrap;
    logic               swap_next;
    logic               active;
    logic               de_raw;
    logic               hs_raw;
    logic               vs_raw;
    logic [X_WIDTH-1:0] x_next;
    logic [Y_WIDTH-1:0] y_next;
    logic [2:0]         sync_raw;
    logic [2:0]         sync_out;

    // Next raster position: h wraps at end of line and carries into v.
    always_comb begin
        last_h = (h_reg == H_LAST);
        last_v = (v_reg == V_LAST);
        h_next = last_h ? '0 : h_reg + H_W'(1);
        v_next = v_reg;
        if (last_h) begin
            v_next = last_v ? '0 : v_reg + V_W'(1);
        end
    end

    assign frame_wrap = last_h && last_v;
    // Swap fires as the raster steps onto the first blanking line.
    assign swap_next  = last_h && (v_reg == V_LAST_ACT);

    assign active = (h_reg < H_ACT) && (v_reg < V_ACT);
    assign de_raw = active;
    assign hs_raw = ((h_reg >= H_SYNC_FIRST) && (h_reg <= H_SYNC_LAST)) ? HOR_SYNC_POLARITY : ~HOR_SYNC_POLARITY;
    assign vs_raw = ((v_reg >= V_SYNC_FIRST) && (v_reg <= V_SYNC_LAST)) ? VER_SYNC_POLARITY : ~VER_SYNC_POLARITY;

    // Source coordinates for low-resolution frame buffers.
    assign x_next = X_WIDTH'(h_reg >> scale_reg);
    assign y_next = Y_WIDTH'(v_reg >> scale_reg);

    // Raster counters, coordinate registers, scale latch, swap strobe and frame count.
    always_ff @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            h_reg         <= '0;
            v_reg         <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            scale_reg     <= SCALE_1X;
            swap_reg      <= 1'b0;
            frame_cnt_reg <= '0;
        end else if (ce) begin
            h_reg    <= h_next;
            v_reg    <= v_next;
            swap_reg <= swap_next;
            // Blanking positions keep the last visible address so readers never see out-of-range values.
            if (active) begin
                x_reg <= x_next;
                y_reg <= y_next;
            end
            // The new scale must apply to the whole next frame, so it is taken only at the wrap.
            if (frame_wrap) begin
                scale_reg <= clamp_scale(scale);
            end
            if (swap_next) begin
                frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_WIDTH'(1);
            end
        end
    end

    assign sync_raw = {de_raw, vs_raw, hs_raw};

    sync_delay_line #(
        .WIDTH       (3),
        .DEPTH       (LOOKAHEAD),
        .RESET_VALUE (SYNC_IDLE)
    ) u_sync_delay (
        .clk   (clk_rgb),
        .rst_n (rst_n),
        .ce    (ce),
        .din   (sync_raw),
        .dout  (sync_out)
    );

    assign de           = sync_out[2];
    assign vs           = sync_out[1];
    assign hs           = sync_out[0];
    assign x            = x_reg;
    assign y            = y_reg;
    assign swap         = swap_reg;
    assign frame_cnt    = frame_cnt_reg;
    assign scale_active = scale_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a reduced raster (56x40 total,
// 40x30 active) so that many frames fit in a short run.  The reference model
// derives every expected output from the count of enabled clock edges since
// reset using plain division/modulo on the raster geometry.
module tb_video_timing_gen;

    localparam int   HT  = 56;
    localparam int   HA  = 40;
    localparam int   HFP = 4;
    localparam int   HS  = 6;
    localparam int   VT  = 40;
    localparam int   VA  = 30;
    localparam int   VFP = 3;
    localparam int   VS  = 2;
    localparam logic HP  = 1'b0;
    localparam logic VP  = 1'b1;
    localparam int   LA  = 2;
    localparam int   FCW = 3;
    localparam int   FT  = HT * VT;
    localparam int   XW  = $clog2(HA);
    localparam int   YW  = $clog2(VA);

    logic           clk_rgb = 1'b0;
    logic           rst_n   = 1'b0;
    logic           ce      = 1'b0;
    logic [1:0]     scale   = 2'd0;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           hs;
    logic           vs;
    logic           de;
    logic           swap;
    logic [FCW-1:0] frame_cnt;
    logic [1:0]     scale_active;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state: enabled edges since reset, scale of the current frame, held coordinates.
    int n = 0;
    int cur_scale = 0;
    int exp_x = 0;
    int exp_y = 0;
    int swap_run = 0;

    video_timing_gen #(
        .HOR_TOTAL_PIXELS       (HT),
        .HOR_ACTIVE_PIXELS      (HA),
        .HOR_FRONT_PORCH_PIXELS (HFP),
        .HOR_SYNC_PIXELS        (HS),
        .HOR_SYNC_POLARITY      (HP),
        .VER_TOTAL_PIXELS       (VT),
        .VER_ACTIVE_PIXELS      (VA),
        .VER_FRONT_PORCH_PIXELS (VFP),
        .VER_SYNC_PIXELS        (VS),
        .VER_SYNC_POLARITY      (VP),
        .LOOKAHEAD              (LA),
        .FRAME_CNT_WIDTH        (FCW)
    ) dut (
        .clk_rgb      (clk_rgb),
        .rst_n        (rst_n),
        .ce           (ce),
        .scale        (scale),
        .x            (x),
        .y            (y),
        .hs           (hs),
        .vs           (vs),
        .de           (de),
        .swap         (swap),
        .frame_cnt    (frame_cnt),
        .scale_active (scale_active)
    );

    always #5 clk_rgb = ~clk_rgb;

    function automatic int hpos(input int p);
        return p % HT;
    endfunction

    function automatic int vpos(input int p);
        return (p / HT) % VT;
    endfunction

    function automatic bit in_active(input int p);
        return (hpos(p) < HA) && (vpos(p) < VA);
    endfunction

    // Outputs after nn edges describe raster position nn-1-LA.
    function automatic logic exp_de(input int nn);
        int m = nn - 1 - LA;
        if (m < 0) return 1'b0;
        return in_active(m);
    endfunction

    function automatic logic exp_hs(input int nn);
        int m = nn - 1 - LA;
        if (m < 0) return ~HP;
        return (hpos(m) >= HA + HFP && hpos(m) < HA + HFP + HS) ? HP : ~HP;
    endfunction

    function automatic logic exp_vs(input int nn);
        int m = nn - 1 - LA;
        if (m < 0) return ~VP;
        return (vpos(m) >= VA + VFP && vpos(m) < VA + VFP + VS) ? VP : ~VP;
    endfunction

    function automatic int exp_fc(input int nn);
        if (nn < VA * HT) return 0;
        return ((nn - VA * HT) / FT + 1) % (1 << FCW);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t, n=%0d)", name, act, expv, $time, n);
        end
    endtask

    // Reference model: advances one raster position per enabled edge.
    always @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            n         <= 0;
            cur_scale <= 0;
            exp_x     <= 0;
            exp_y     <= 0;
        end else if (ce) begin
            if (in_active(n)) begin
                exp_x <= hpos(n) >> cur_scale;
                exp_y <= vpos(n) >> cur_scale;
            end
            if (n % FT == FT - 1) begin
                cur_scale <= (scale > 2'd2) ? 2 : int'(scale);
            end
            n <= n + 1;
        end
    end

    // Per-cycle comparison of every output against the model, plus swap pulse width in ce cycles.
    initial begin
        forever begin
            @(posedge clk_rgb);
            #2;
            if (chk_en) begin
                chk("x", x, exp_x);
                chk("y", y, exp_y);
                chk("de", de, exp_de(n));
                chk("hs", hs, exp_hs(n));
                chk("vs", vs, exp_vs(n));
                chk("swap", swap, (n % FT == VA * HT) ? 1 : 0);
                chk("frame_cnt", frame_cnt, exp_fc(n));
                chk("scale_active", scale_active, cur_scale);
                if (!rst_n) begin
                    swap_run = 0;
                end else if (ce) begin
                    if (swap === 1'b1) begin
                        swap_run++;
                    end else begin
                        if (swap_run != 0) chk("swap_width", swap_run, 1);
                        swap_run = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One edge: drive inputs on the falling edge, return shortly after the rising edge.
    task automatic cyc(input logic ce_v, input logic [1:0] sc_v);
        @(negedge clk_rgb);
        ce    = ce_v;
        scale = sc_v;
        @(posedge clk_rgb);
        #3;
    endtask

    // After a reset release with ce held high: de lead and x alignment on the first line.
    task automatic first_line_check(input string tag);
        logic [XW-1:0] xs [0:HT+LA+4];
        logic          ds [0:HT+LA+4];
        int rise;
        int fall;
        rise = -1;
        fall = -1;
        xs[0] = x;
        ds[0] = de;
        for (int i = 1; i <= HT + LA + 4; i++) begin
            cyc(1'b1, 2'd0);
            xs[i] = x;
            ds[i] = de;
        end
        for (int i = 0; i <= HT + LA + 4; i++) begin
            if (ds[i] && rise < 0) rise = i;
        end
        if (rise >= 0) begin
            fall = rise;
            while (fall < HT + LA + 4 && ds[fall+1]) fall++;
        end
        chk({tag, "_de_rise_edge"}, rise, LA + 1);
        chk({tag, "_de_line_len"}, fall - rise + 1, 40);
        if (rise >= LA) chk({tag, "_x_first"}, xs[rise-LA], 0);
        if (fall >= LA) chk({tag, "_x_last"}, xs[fall-LA], 39);
    endtask

    task automatic run_to_boundary(input logic [1:0] sc, output int mx, output int my);
        int i;
        mx = 0;
        my = 0;
        i = 0;
        do begin
            cyc(1'b1, sc);
            if (de && int'(x) > mx) mx = int'(x);
            if (de && int'(y) > my) my = int'(y);
            i++;
        end while (n % FT != 0 && i < 2 * FT);
        chk("frame_boundary_reached", (n % FT == 0) ? 1 : 0, 1);
    endtask

    task automatic run_n(input int cnt, input logic [1:0] sc, output int mx, output int my);
        mx = 0;
        my = 0;
        for (int i = 0; i < cnt; i++) begin
            cyc(1'b1, sc);
            if (de && int'(x) > mx) mx = int'(x);
            if (de && int'(y) > my) my = int'(y);
        end
    endtask

    initial begin
        int de_cnt;
        int hs_cnt;
        int vs_cnt;
        int sw_cnt;
        int sw_first;
        int sw_second;
        int mx;
        int my;
        logic ce_v;
        logic [1:0] sc_v;

        // Reset state (hs idle high, vs idle low with these polarities).
        repeat (3) @(posedge clk_rgb);
        #3;
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 0);
        chk("rst_de", de, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_swap", swap, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_scale_active", scale_active, 0);
        chk_en = 1'b1;

        @(negedge clk_rgb);
        rst_n = 1'b1;
        first_line_check("boot");

        // Two frames with ce held high: per-frame counts and swap period.
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; sw_cnt = 0; sw_first = -1; sw_second = -1;
        for (int i = 0; i < 2 * FT; i++) begin
            cyc(1'b1, 2'd0);
            if (de) de_cnt++;
            if (hs == HP) hs_cnt++;
            if (vs == VP) vs_cnt++;
            if (swap) begin
                sw_cnt++;
                if (sw_first < 0) sw_first = i; else sw_second = i;
            end
        end
        chk("two_frame_de_cycles", de_cnt, 2400);
        chk("two_frame_hs_cycles", hs_cnt, 480);
        chk("two_frame_vs_cycles", vs_cnt, 224);
        chk("two_frame_swaps", sw_cnt, 2);
        chk("frame_period", sw_second - sw_first, 2240);

        // scale=1 requested mid-frame: current frame still full resolution.
        run_to_boundary(2'd1, mx, my);
        chk("midframe_2x_xmax", mx, 39);
        chk("midframe_2x_ymax", my, 29);
        chk("scale_active_2x", scale_active, 1);
        run_n(FT, 2'd1, mx, my);
        chk("frame_2x_xmax", mx, 19);
        chk("frame_2x_ymax", my, 14);

        // scale=3 requested mid-frame: behaves as 4x from the next frame.
        run_n(FT / 2, 2'd3, mx, my);
        run_to_boundary(2'd3, mx, my);
        chk("midframe_4x_xmax", mx, 19);
        chk("midframe_4x_ymax", my, 14);
        chk("scale_active_4x", scale_active, 2);
        run_n(FT, 2'd3, mx, my);
        chk("frame_4x_xmax", mx, 9);
        chk("frame_4x_ymax", my, 7);

        // Randomised ce and occasional scale changes, with a 100-cycle stall mid-line.
        sc_v = 2'd0;
        for (int i = 0; i < 5 * FT; i++) begin
            ce_v = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 499) == 0) sc_v = 2'($urandom_range(0, 3));
            cyc(ce_v, sc_v);
            if (i == FT) begin
                for (int k = 0; k < HT && hpos(n) != HA / 2; k++) cyc(1'b1, sc_v);
                repeat (100) cyc(1'b0, sc_v);
            end
        end

        // Stall across the swap point: strobe held, not re-issued on resume.
        for (int i = 0; i < 2 * FT && swap !== 1'b1; i++) cyc(1'b1, 2'd0);
        chk("swap_reached", swap, 1);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 2'd0);
            chk("swap_held_ce0", swap, 1);
        end
        cyc(1'b1, 2'd0);
        chk("swap_after_resume", swap, 0);

        // Asynchronous reset in the middle of hsync, between clock edges.
        for (int i = 0; i < 4 * HT && hs !== HP; i++) cyc(1'b1, 2'd0);
        chk("hsync_reached", hs, HP);
        cyc(1'b1, 2'd0);
        cyc(1'b1, 2'd0);
        #1;
        rst_n = 1'b0;
        ce    = 1'b0;
        #1;
        chk("async_rst_hs", hs, 1);
        chk("async_rst_vs", vs, 0);
        chk("async_rst_de", de, 0);
        chk("async_rst_frame_cnt", frame_cnt, 0);
        chk("async_rst_swap", swap, 0);
        chk("async_rst_x", x, 0);
        chk("async_rst_scale", scale_active, 0);
        repeat (2) @(posedge clk_rgb);
        @(negedge clk_rgb);
        rst_n = 1'b1;
        first_line_check("rerst");

        for (int i = 0; i < FT; i++) begin
            cyc(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
